// File: rtl/ram_port_arbiter_pkg.sv
// Shared types and constants for the two-master RAM port A arbiter.
package ram_port_arbiter_pkg;

  typedef logic [1:0] arb_state_t;

  localparam arb_state_t IDLE    = 2'd0;
  localparam arb_state_t LOCK_M0 = 2'd1;
  localparam arb_state_t LOCK_M1 = 2'd2;

  // Master indices into grant/valid vectors.
  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

endpackage

// File: rtl/ram_port_arbiter_arb_rr2.sv
// Two-way grant logic: fixed priority to M0 or round-robin against the last served master.
module arb_rr2
  import ram_port_arbiter_pkg::*;
#(
  parameter int PRIORITY_M0 = 0
) (
  input  logic [1:0] valid,
  input  logic       last,
  output logic [1:0] grant
);

  always_comb begin
    grant     = '0;
    grant[M0] = valid[M0] & (~valid[M1] | (PRIORITY_M0 != 0) | (last == M1));
    grant[M1] = valid[M1] & ~grant[M0];
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares RAM port A between two valid/ready requesters with optional locked bursts
// and a registered one-cycle response per accepted beat.
module ram_port_arbiter
  import ram_port_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 256,
  parameter int PRIORITY_M0 = 0,
  parameter int LOCK_MAX    = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  m0_valid,
  output logic                  m0_ready,
  input  logic                  m0_we,
  input  logic                  m0_lock,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  output logic                  m0_rsp_valid,
  output logic                  m0_rsp_err,
  output logic [DATA_WIDTH-1:0] m0_rsp_rdata,
  input  logic                  m1_valid,
  output logic                  m1_ready,
  input  logic                  m1_we,
  input  logic                  m1_lock,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  output logic                  m1_rsp_valid,
  output logic                  m1_rsp_err,
  output logic [DATA_WIDTH-1:0] m1_rsp_rdata,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata
);

  localparam int CntW = $clog2(LOCK_MAX + 1);
  localparam logic [ADDR_WIDTH:0] AddrLimit = (ADDR_WIDTH + 1)'(DEPTH);

  arb_state_t            state_q, state_d;
  logic                  last_q, last_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [1:0]            rsp_valid_q, rsp_valid_d;
  logic                  rsp_err_q, rsp_err_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;

  logic [1:0]            arb_grant, grant;
  logic                  accept, sel, we_sel, lock_sel, in_range;
  logic [ADDR_WIDTH-1:0] addr_sel;
  logic [DATA_WIDTH-1:0] wdata_sel;

  arb_rr2 #(
    .PRIORITY_M0(PRIORITY_M0)
  ) u_arb (
    .valid({m1_valid, m0_valid}),
    .last (last_q),
    .grant(arb_grant)
  );

  // A held lock excludes the other master regardless of its valid.
  always_comb begin
    grant = '0;
    case (state_q)
      IDLE:    grant = arb_grant;
      LOCK_M0: grant[M0] = m0_valid;
      LOCK_M1: grant[M1] = m1_valid;
      default: grant = '0;
    endcase
  end

  assign m0_ready  = grant[M0];
  assign m1_ready  = grant[M1];
  assign accept    = |grant;
  assign sel       = grant[M1];
  assign addr_sel  = sel ? m1_addr : m0_addr;
  assign wdata_sel = sel ? m1_wdata : m0_wdata;
  assign we_sel    = sel ? m1_we : m0_we;
  assign lock_sel  = sel ? m1_lock : m0_lock;
  assign in_range  = {1'b0, addr_sel} < AddrLimit;

  assign ram_we    = accept & we_sel & in_range;
  assign ram_addr  = accept ? addr_sel : '0;
  assign ram_wdata = accept ? wdata_sel : '0;

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    if (accept) begin
      last_d = sel;
      if (state_q == IDLE) begin
        if (lock_sel && LOCK_MAX > 1) begin
          state_d = sel ? LOCK_M1 : LOCK_M0;
          cnt_d   = CntW'(1);
        end
      end else if (lock_sel && (int'(cnt_q) + 1 < LOCK_MAX)) begin
        cnt_d = cnt_q + 1'b1;
      end else begin
        // Lock released by the master, or forced after LOCK_MAX consecutive beats.
        state_d = IDLE;
        cnt_d   = '0;
      end
    end
  end

  always_comb begin
    rsp_valid_d = grant;
    rsp_err_d   = accept & ~in_range;
    rsp_rdata_d = (accept && !we_sel && in_range) ? ram_rdata : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      last_q      <= M1;
      cnt_q       <= '0;
      rsp_valid_q <= '0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign m0_rsp_valid = rsp_valid_q[M0];
  assign m0_rsp_err   = rsp_valid_q[M0] & rsp_err_q;
  assign m0_rsp_rdata = rsp_valid_q[M0] ? rsp_rdata_q : '0;
  assign m1_rsp_valid = rsp_valid_q[M1];
  assign m1_rsp_err   = rsp_valid_q[M1] & rsp_err_q;
  assign m1_rsp_rdata = rsp_valid_q[M1] ? rsp_rdata_q : '0;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench: round-robin instance with a RAM model, plus a fixed-priority instance.
module tb_ram_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        m0_valid = 0, m0_we = 0, m0_lock = 0;
  logic [31:0] m0_addr = 0, m0_wdata = 0;
  logic        m1_valid = 0, m1_we = 0, m1_lock = 0;
  logic [31:0] m1_addr = 0, m1_wdata = 0;

  logic        m0_ready, m0_rsp_valid, m0_rsp_err;
  logic [31:0] m0_rsp_rdata;
  logic        m1_ready, m1_rsp_valid, m1_rsp_err;
  logic [31:0] m1_rsp_rdata;
  logic        ram_we;
  logic [31:0] ram_addr, ram_wdata, ram_rdata;

  logic        p_m0_ready, p_m0_rsp_valid, p_m0_rsp_err;
  logic [31:0] p_m0_rsp_rdata;
  logic        p_m1_ready, p_m1_rsp_valid, p_m1_rsp_err;
  logic [31:0] p_m1_rsp_rdata;
  logic        p_ram_we;
  logic [31:0] p_ram_addr, p_ram_wdata;

  logic [31:0] mem [0:255];
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  assign ram_rdata = (ram_addr < 32'd256) ? mem[ram_addr[7:0]] : 32'h0;
  always @(posedge clk) if (ram_we) mem[ram_addr[7:0]] <= ram_wdata;

  ram_port_arbiter #(.PRIORITY_M0(0), .LOCK_MAX(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_valid(m0_valid), .m0_ready(m0_ready), .m0_we(m0_we), .m0_lock(m0_lock),
    .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_rsp_valid(m0_rsp_valid),
    .m0_rsp_err(m0_rsp_err), .m0_rsp_rdata(m0_rsp_rdata),
    .m1_valid(m1_valid), .m1_ready(m1_ready), .m1_we(m1_we), .m1_lock(m1_lock),
    .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_rsp_valid(m1_rsp_valid),
    .m1_rsp_err(m1_rsp_err), .m1_rsp_rdata(m1_rsp_rdata),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  ram_port_arbiter #(.PRIORITY_M0(1), .LOCK_MAX(8)) dut_prio (
    .clk(clk), .rst_n(rst_n),
    .m0_valid(m0_valid), .m0_ready(p_m0_ready), .m0_we(1'b0), .m0_lock(1'b0),
    .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_rsp_valid(p_m0_rsp_valid),
    .m0_rsp_err(p_m0_rsp_err), .m0_rsp_rdata(p_m0_rsp_rdata),
    .m1_valid(m1_valid), .m1_ready(p_m1_ready), .m1_we(1'b0), .m1_lock(1'b0),
    .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_rsp_valid(p_m1_rsp_valid),
    .m1_rsp_err(p_m1_rsp_err), .m1_rsp_rdata(p_m1_rsp_rdata),
    .ram_we(p_ram_we), .ram_addr(p_ram_addr), .ram_wdata(p_ram_wdata), .ram_rdata(32'h0)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[0]   = 32'hDEAD_BEEF;
    mem[5]   = 32'h0000_00A5;
    mem[255] = 32'h0000_00FF;

    // Reset state
    repeat (2) @(posedge clk);
    #2;
    chk("rst_m0_rsp_valid", {31'b0, m0_rsp_valid}, 32'd0);
    chk("rst_m1_rsp_valid", {31'b0, m1_rsp_valid}, 32'd0);
    chk("rst_ready", {30'b0, m1_ready, m0_ready}, 32'd0);
    chk("rst_ram_addr", ram_addr, 32'd0);
    rst_n = 1'b1;

    // Lone M0 read of address 5
    m0_valid = 1; m0_addr = 5;
    #1;
    chk("rd5_m0_ready", {31'b0, m0_ready}, 32'd1);
    chk("rd5_ram_addr", ram_addr, 32'd5);
    chk("rd5_ram_we", {31'b0, ram_we}, 32'd0);
    tick();
    m0_valid = 0;
    chk("rd5_rsp_valid", {31'b0, m0_rsp_valid}, 32'd1);
    chk("rd5_rsp_rdata", m0_rsp_rdata, 32'h0000_00A5);
    chk("rd5_rsp_err", {31'b0, m0_rsp_err}, 32'd0);
    chk("rd5_m1_rsp_valid", {31'b0, m1_rsp_valid}, 32'd0);
    #1;
    chk("idle_ready", {30'b0, m1_ready, m0_ready}, 32'd0);
    chk("idle_ram_addr", ram_addr, 32'd0);
    chk("idle_ram_we", {31'b0, ram_we}, 32'd0);

    // Contention: M0 was served last, so M1 wins first, then grants alternate
    m0_valid = 1; m0_addr = 5; m1_valid = 1; m1_addr = 7;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("rr_m1_ready", {31'b0, m1_ready}, (i % 2 == 0) ? 32'd1 : 32'd0);
      chk("rr_m0_ready", {31'b0, m0_ready}, (i % 2 == 0) ? 32'd0 : 32'd1);
      chk("prio_m0_ready", {31'b0, p_m0_ready}, 32'd1);
      chk("prio_m1_ready", {31'b0, p_m1_ready}, 32'd0);
      tick();
      chk("rr_m1_rsp_valid", {31'b0, m1_rsp_valid}, (i % 2 == 0) ? 32'd1 : 32'd0);
      chk("rr_m0_rsp_valid", {31'b0, m0_rsp_valid}, (i % 2 == 0) ? 32'd0 : 32'd1);
    end

    // M1 locked write burst to address 7; M0 waits for the lock=0 beat
    m1_we = 1; m1_addr = 7; m1_wdata = 32'h1234; m1_lock = 1;
    m0_we = 0; m0_addr = 7;
    #1;
    chk("lk_b1_m1_ready", {31'b0, m1_ready}, 32'd1);
    chk("lk_b1_ram_we", {31'b0, ram_we}, 32'd1);
    tick();
    #1;
    chk("lk_b2_ready", {30'b0, m1_ready, m0_ready}, 32'd2);
    tick();
    m1_lock = 0;
    #1;
    chk("lk_b3_ready", {30'b0, m1_ready, m0_ready}, 32'd2);
    tick();
    m1_valid = 0; m1_we = 0;
    chk("lk_m1_rsp_valid", {31'b0, m1_rsp_valid}, 32'd1);
    chk("lk_m1_rsp_rdata", m1_rsp_rdata, 32'd0);
    #1;
    chk("lk_m0_granted", {30'b0, m1_ready, m0_ready}, 32'd1);
    chk("lk_m0_ram_addr", ram_addr, 32'd7);
    tick();
    m0_valid = 0;
    chk("lk_rd7_rdata", m0_rsp_rdata, 32'h1234);

    // Continuous M1 lock: forced release after 8 beats, then M0 wins the tie
    m0_valid = 1; m0_addr = 5;
    m1_valid = 1; m1_addr = 8; m1_lock = 1;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("force_m1_beat", {30'b0, m1_ready, m0_ready}, 32'd2);
      tick();
    end
    #1;
    chk("force_m0_granted", {30'b0, m1_ready, m0_ready}, 32'd1);
    tick();
    m0_valid = 0; m1_valid = 0; m1_lock = 0;
    chk("force_m0_rsp", m0_rsp_rdata, 32'h0000_00A5);

    // Out of range write at DEPTH, then in-range boundary read at DEPTH-1
    m0_valid = 1; m0_we = 1; m0_addr = 256; m0_wdata = 32'h5555_5555;
    #1;
    chk("oor_m0_ready", {31'b0, m0_ready}, 32'd1);
    chk("oor_ram_we", {31'b0, ram_we}, 32'd0);
    tick();
    m0_we = 0; m0_addr = 255;
    chk("oor_rsp", {m0_rsp_rdata[29:0], m0_rsp_err, m0_rsp_valid}, 32'd3);
    chk("oor_mem0", mem[0], 32'hDEAD_BEEF);
    tick();
    m0_valid = 0;
    chk("b255_rsp_err", {31'b0, m0_rsp_err}, 32'd0);
    chk("b255_rsp_rdata", m0_rsp_rdata, 32'h0000_00FF);

    // Reset asserted in LOCK_M1 with a response pending
    m0_valid = 1; m0_addr = 5;
    m1_valid = 1; m1_we = 1; m1_addr = 9; m1_wdata = 32'h99; m1_lock = 1;
    tick();
    chk("rstm_pending", {31'b0, m1_rsp_valid}, 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rstm_rsp_dropped", {31'b0, m1_rsp_valid}, 32'd0);
    #2;
    rst_n = 1'b1;
    #1;
    chk("rstm_tie_m0", {30'b0, m1_ready, m0_ready}, 32'd1);
    m0_valid = 0; m1_valid = 0; m1_we = 0; m1_lock = 0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
